// File: rtl/byteswap_counter_pkg.sv
// Shared types and helpers for the byteswap multi-channel counter bank.
// Optional sticky boundary flags are enabled with BYTESWAP_COUNTER_STICKY_EN.
package byteswap_counter_pkg;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } mode_e;

  localparam int C_MAX_WIDTH = 32;
  localparam int C_BUS_MAX   = 16 * C_MAX_WIDTH;

  function automatic logic [C_MAX_WIDTH-1:0] f_zero_of(input int width);
    f_zero_of = '0;
    if (width < 0) f_zero_of = '0;
  endfunction

  function automatic logic [C_MAX_WIDTH-1:0] f_one_of(input int width);
    f_one_of = (width > 0) ? C_MAX_WIDTH'(1) : '0;
  endfunction

  function automatic logic [C_MAX_WIDTH-1:0] f_max_of(input int width);
    logic [C_MAX_WIDTH:0] v;
    v        = (C_MAX_WIDTH+1)'(1) << width;
    f_max_of = C_MAX_WIDTH'(v - (C_MAX_WIDTH+1)'(1));
  endfunction

  // Channel idx of a bus packed as [idx*width +: width]; caller truncates.
  function automatic logic [C_MAX_WIDTH-1:0] f_unpack(input logic [C_BUS_MAX-1:0] bus,
                                                      input int idx, input int width);
    f_unpack = C_MAX_WIDTH'(bus >> (idx * width));
  endfunction

endpackage

// File: rtl/byteswap_multi_counter_if.sv
// Strobe/bus bundle between control logic (master) and the counter bank (slave).
// BYTESWAP_COUNTER_STICKY_EN adds sticky_clr / sticky.
interface byteswap_multi_counter_if #(
  parameter int C_CHANNELS   = 2,
  parameter int C_WIDTH      = 8,
  parameter int C_STEP_WIDTH = 4
);
  // No valid/ready: every strobe is sampled on each rising edge while clken is high,
  // and every output is a registered value valid one cycle after its strobe.
  logic                             clken;
  logic [C_CHANNELS-1:0]            load;
  logic [C_CHANNELS-1:0]            incr;
  logic [C_CHANNELS-1:0]            decr;
  logic [C_CHANNELS*C_WIDTH-1:0]    load_value;
  logic [C_CHANNELS*C_STEP_WIDTH-1:0] step;
  logic [C_CHANNELS*C_WIDTH-1:0]    count;
  logic [C_CHANNELS-1:0]            is_zero;
  logic [C_CHANNELS-1:0]            is_max;
  logic [C_CHANNELS-1:0]            bound_evt;
`ifdef BYTESWAP_COUNTER_STICKY_EN
  logic [C_CHANNELS-1:0]            sticky_clr;
  logic [C_CHANNELS-1:0]            sticky;

  modport master (output clken, load, incr, decr, load_value, step, sticky_clr,
                  input  count, is_zero, is_max, bound_evt, sticky);
  modport slave  (input  clken, load, incr, decr, load_value, step, sticky_clr,
                  output count, is_zero, is_max, bound_evt, sticky);
`else
  modport master (output clken, load, incr, decr, load_value, step,
                  input  count, is_zero, is_max, bound_evt);
  modport slave  (input  clken, load, incr, decr, load_value, step,
                  output count, is_zero, is_max, bound_evt);
`endif
endinterface

// File: rtl/byteswap_counter_chan.sv
// One counter channel: load/incr/decr with step, wrap or saturate, registered flags.
// BYTESWAP_COUNTER_STICKY_EN adds a sticky boundary flag with its own clear.
module byteswap_counter_chan
  import byteswap_counter_pkg::*;
#(
  parameter int                 C_WIDTH      = 8,
  parameter int                 C_STEP_WIDTH = 4,
  parameter int                 C_SATURATE   = 0,
  parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clken,
  input  logic                    i_load,
  input  logic                    i_incr,
  input  logic                    i_decr,
  input  logic [C_WIDTH-1:0]      i_load_value,
  input  logic [C_STEP_WIDTH-1:0] i_step,
`ifdef BYTESWAP_COUNTER_STICKY_EN
  input  logic                    i_sticky_clr,
  output logic                    o_sticky,
`endif
  output logic [C_WIDTH-1:0]      o_count,
  output logic                    o_is_zero,
  output logic                    o_is_max,
  output logic                    o_bound_evt
);

  localparam mode_e                C_MODE     = (C_SATURATE != 0) ? SAT : WRAP;
  localparam logic [C_WIDTH-1:0]   C_ALL_ONES = C_WIDTH'(f_max_of(C_WIDTH));
  localparam logic [C_WIDTH-1:0]   C_ZERO     = C_WIDTH'(f_zero_of(C_WIDTH));

  logic [C_WIDTH-1:0] r_count;
  logic               r_is_zero;
  logic               r_is_max;
  logic               r_bound_evt;

  logic [C_WIDTH:0]   w_step_ext;
  logic [C_WIDTH:0]   w_sum;
  logic [C_WIDTH:0]   w_diff;
  logic [C_WIDTH-1:0] w_next_count;
  logic               w_next_evt;

  // One extra bit catches carry out of the add and borrow out of the subtract.
  assign w_step_ext = (C_WIDTH+1)'(i_step);
  assign w_sum      = {1'b0, r_count} + w_step_ext;
  assign w_diff     = {1'b0, r_count} - w_step_ext;

  always_comb begin
    w_next_count = r_count;
    w_next_evt   = 1'b0;
    if (i_clken) begin
      if (i_load) begin
        w_next_count = i_load_value;
      end else if (i_incr && !i_decr && (i_step != '0)) begin
        w_next_evt   = w_sum[C_WIDTH];
        w_next_count = (C_MODE == SAT && w_sum[C_WIDTH]) ? C_ALL_ONES : w_sum[C_WIDTH-1:0];
      end else if (i_decr && !i_incr && (i_step != '0)) begin
        w_next_evt   = w_diff[C_WIDTH];
        w_next_count = (C_MODE == SAT && w_diff[C_WIDTH]) ? C_ZERO : w_diff[C_WIDTH-1:0];
      end
    end
  end

  // Flags follow the next count, so they are never a cycle behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= C_INIT;
      r_is_zero   <= (C_INIT == C_ZERO);
      r_is_max    <= (C_INIT == C_ALL_ONES);
      r_bound_evt <= 1'b0;
    end else begin
      r_count     <= w_next_count;
      r_is_zero   <= (w_next_count == C_ZERO);
      r_is_max    <= (w_next_count == C_ALL_ONES);
      r_bound_evt <= w_next_evt;
    end
  end

  assign o_count     = r_count;
  assign o_is_zero   = r_is_zero;
  assign o_is_max    = r_is_max;
  assign o_bound_evt = r_bound_evt;

`ifdef BYTESWAP_COUNTER_STICKY_EN
  logic r_sticky;

  // Set wins over clear; setting is already gated by clken through w_next_evt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_sticky <= 1'b0;
    else if (w_next_evt)   r_sticky <= 1'b1;
    else if (i_sticky_clr) r_sticky <= 1'b0;
  end

  assign o_sticky = r_sticky;
`endif

endmodule

// File: rtl/byteswap_multi_counter.sv
// Bank of C_CHANNELS independent counters; this level only slices the packed buses.
// BYTESWAP_COUNTER_STICKY_EN enables per-channel sticky boundary flags.
module byteswap_multi_counter
  import byteswap_counter_pkg::*;
#(
  parameter int                 C_CHANNELS   = 2,
  parameter int                 C_WIDTH      = 8,
  parameter int                 C_STEP_WIDTH = 4,
  parameter int                 C_SATURATE   = 0,
  parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  byteswap_multi_counter_if.slave bus
);

  if (C_WIDTH < 2 || C_WIDTH > C_MAX_WIDTH) begin : g_bad_width
    $error("byteswap_multi_counter: C_WIDTH must be 2..32");
  end
  if (C_STEP_WIDTH < 1 || C_STEP_WIDTH > C_WIDTH) begin : g_bad_step
    $error("byteswap_multi_counter: C_STEP_WIDTH must be 1..C_WIDTH");
  end
  if (C_CHANNELS < 1 || C_CHANNELS > 16) begin : g_bad_chan
    $error("byteswap_multi_counter: C_CHANNELS must be 1..16");
  end

  logic [C_WIDTH-1:0] w_count     [C_CHANNELS];
  logic               w_is_zero   [C_CHANNELS];
  logic               w_is_max    [C_CHANNELS];
  logic               w_bound_evt [C_CHANNELS];
`ifdef BYTESWAP_COUNTER_STICKY_EN
  logic               w_sticky    [C_CHANNELS];
`endif

  for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_chan
    byteswap_counter_chan #(
      .C_WIDTH      (C_WIDTH),
      .C_STEP_WIDTH (C_STEP_WIDTH),
      .C_SATURATE   (C_SATURATE),
      .C_INIT       (C_INIT)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .i_clken      (bus.clken),
      .i_load       (bus.load[gi]),
      .i_incr       (bus.incr[gi]),
      .i_decr       (bus.decr[gi]),
      .i_load_value (C_WIDTH'(f_unpack(C_BUS_MAX'(bus.load_value), gi, C_WIDTH))),
      .i_step       (C_STEP_WIDTH'(f_unpack(C_BUS_MAX'(bus.step), gi, C_STEP_WIDTH))),
`ifdef BYTESWAP_COUNTER_STICKY_EN
      .i_sticky_clr (bus.sticky_clr[gi]),
      .o_sticky     (w_sticky[gi]),
`endif
      .o_count      (w_count[gi]),
      .o_is_zero    (w_is_zero[gi]),
      .o_is_max     (w_is_max[gi]),
      .o_bound_evt  (w_bound_evt[gi])
    );
  end

  always_comb begin
    bus.count     = '0;
    bus.is_zero   = '0;
    bus.is_max    = '0;
    bus.bound_evt = '0;
`ifdef BYTESWAP_COUNTER_STICKY_EN
    bus.sticky    = '0;
`endif
    for (int i = 0; i < C_CHANNELS; i++) begin
      bus.count[i*C_WIDTH +: C_WIDTH] = w_count[i];
      bus.is_zero[i]                  = w_is_zero[i];
      bus.is_max[i]                   = w_is_max[i];
      bus.bound_evt[i]                = w_bound_evt[i];
`ifdef BYTESWAP_COUNTER_STICKY_EN
      bus.sticky[i]                   = w_sticky[i];
`endif
    end
  end

endmodule

// File: tb/tb_byteswap_multi_counter.sv
// Directed bench: a wrap-mode bank (init 4'hF) and a saturate-mode bank (init 0),
// both 2 channels x 4 bits with 2-bit steps; hand-computed expectations.
module tb_byteswap_multi_counter;

  localparam int CH = 2;
  localparam int W  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  byteswap_multi_counter_if #(.C_CHANNELS(CH), .C_WIDTH(W), .C_STEP_WIDTH(SW)) a_if ();
  byteswap_multi_counter_if #(.C_CHANNELS(CH), .C_WIDTH(W), .C_STEP_WIDTH(SW)) b_if ();

  byteswap_multi_counter #(
    .C_CHANNELS(CH), .C_WIDTH(W), .C_STEP_WIDTH(SW), .C_SATURATE(0), .C_INIT(4'hF)
  ) u_dut_wrap (.clk(clk), .rst(rst), .bus(a_if.slave));

  byteswap_multi_counter #(
    .C_CHANNELS(CH), .C_WIDTH(W), .C_STEP_WIDTH(SW), .C_SATURATE(1), .C_INIT(4'h0)
  ) u_dut_sat (.clk(clk), .rst(rst), .bus(b_if.slave));

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic [1:0] ld, input logic [1:0] inc, input logic [1:0] dec,
                         input logic [7:0] lv, input logic [3:0] st);
    a_if.load = ld; a_if.incr = inc; a_if.decr = dec; a_if.load_value = lv; a_if.step = st;
  endtask

  task automatic b_drive(input logic [1:0] ld, input logic [1:0] inc, input logic [1:0] dec,
                         input logic [7:0] lv, input logic [3:0] st);
    b_if.load = ld; b_if.incr = inc; b_if.decr = dec; b_if.load_value = lv; b_if.step = st;
  endtask

  task automatic a_check(input string tag, input logic [7:0] cnt, input logic [1:0] z,
                         input logic [1:0] m, input logic [1:0] e);
    check({tag, ".count"},   32'(a_if.count),     32'(cnt));
    check({tag, ".is_zero"}, 32'(a_if.is_zero),   32'(z));
    check({tag, ".is_max"},  32'(a_if.is_max),    32'(m));
    check({tag, ".bound"},   32'(a_if.bound_evt), 32'(e));
  endtask

  task automatic b_check(input string tag, input logic [7:0] cnt, input logic [1:0] z,
                         input logic [1:0] m, input logic [1:0] e);
    check({tag, ".count"},   32'(b_if.count),     32'(cnt));
    check({tag, ".is_zero"}, 32'(b_if.is_zero),   32'(z));
    check({tag, ".is_max"},  32'(b_if.is_max),    32'(m));
    check({tag, ".bound"},   32'(b_if.bound_evt), 32'(e));
  endtask

  initial begin
    a_if.clken = 1'b1; b_if.clken = 1'b1;
    a_drive(2'b00, 2'b00, 2'b00, 8'h00, 4'h0);
    b_drive(2'b00, 2'b00, 2'b00, 8'h00, 4'h0);
`ifdef BYTESWAP_COUNTER_STICKY_EN
    a_if.sticky_clr = 2'b00; b_if.sticky_clr = 2'b00;
`endif
    rst = 1'b1;
    repeat (2) tick();
    a_check("a_reset", 8'hFF, 2'b00, 2'b11, 2'b00);
    b_check("b_reset", 8'h00, 2'b11, 2'b00, 2'b00);
`ifdef BYTESWAP_COUNTER_STICKY_EN
    check("a_reset.sticky", 32'(a_if.sticky), 32'h0);
`endif
    rst = 1'b0;
    tick();

    // wrap: ch0 load 14, incr by 3 -> 1 with a one-cycle event
    a_drive(2'b01, 2'b00, 2'b00, 8'h0E, 4'h0); tick();
    a_check("a_load14", 8'hFE, 2'b00, 2'b10, 2'b00);
    a_drive(2'b00, 2'b01, 2'b00, 8'h00, 4'h3); tick();
    a_check("a_wrap_up", 8'hF1, 2'b00, 2'b10, 2'b01);
    a_drive(2'b00, 2'b00, 2'b00, 8'h00, 4'h0); tick();
    a_check("a_evt_drop", 8'hF1, 2'b00, 2'b10, 2'b00);

    // asynchronous reset mid-count, with a pending strobe held through reset
    a_drive(2'b00, 2'b01, 2'b00, 8'h00, 4'h1); tick();
    a_check("a_count2", 8'hF2, 2'b00, 2'b10, 2'b00);
    rst = 1'b1;
    #1;
    a_check("a_async_rst", 8'hFF, 2'b00, 2'b11, 2'b00);
    tick();
    a_check("a_rst_hold", 8'hFF, 2'b00, 2'b11, 2'b00);
    rst = 1'b0;
    a_drive(2'b00, 2'b00, 2'b00, 8'h00, 4'h0); tick();
    a_check("a_post_rst", 8'hFF, 2'b00, 2'b11, 2'b00);

    // priority: load beats incr/decr; both strobes hold; both channels update together
    a_drive(2'b01, 2'b01, 2'b01, 8'h05, 4'h1); tick();
    a_check("a_load_prio", 8'hF5, 2'b00, 2'b10, 2'b00);
    a_drive(2'b00, 2'b01, 2'b01, 8'h00, 4'h1); tick();
    a_check("a_both_hold", 8'hF5, 2'b00, 2'b10, 2'b00);
    a_drive(2'b00, 2'b11, 2'b00, 8'h00, 4'b1001); tick();
    a_check("a_dual_incr", 8'h16, 2'b00, 2'b00, 2'b10);

    // clken low: everything holds and the event clears
    a_if.clken = 1'b0;
    a_drive(2'b00, 2'b11, 2'b00, 8'h00, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      a_check($sformatf("a_clken_off%0d", i), 8'h16, 2'b00, 2'b00, 2'b00);
    end
    a_if.clken = 1'b1;

    // decrement to exactly zero (no event), then borrow-wrap to 15; step 0 is a no-op
    a_drive(2'b00, 2'b00, 2'b01, 8'h00, 4'h3); tick();
    a_check("a_dec_3", 8'h13, 2'b00, 2'b00, 2'b00);
    tick();
    a_check("a_dec_0", 8'h10, 2'b01, 2'b00, 2'b00);
    a_drive(2'b00, 2'b00, 2'b01, 8'h00, 4'h1); tick();
    a_check("a_wrap_down", 8'h1F, 2'b00, 2'b01, 2'b01);
    a_drive(2'b00, 2'b01, 2'b00, 8'h00, 4'h0); tick();
    a_check("a_step0", 8'h1F, 2'b00, 2'b01, 2'b00);
    a_drive(2'b00, 2'b00, 2'b00, 8'h00, 4'h0);

`ifdef BYTESWAP_COUNTER_STICKY_EN
    check("a_sticky_both", 32'(a_if.sticky), 32'h3);
    a_if.sticky_clr = 2'b11; tick();
    check("a_sticky_clr_all", 32'(a_if.sticky), 32'h0);
    a_if.sticky_clr = 2'b00;
    a_drive(2'b01, 2'b00, 2'b00, 8'h0F, 4'h0); tick();
    a_drive(2'b00, 2'b01, 2'b00, 8'h00, 4'h1); tick();
    check("a_sticky_set", 32'(a_if.sticky), 32'h1);
    check("a_sticky_cnt", 32'(a_if.count), 32'h10);
    a_drive(2'b00, 2'b00, 2'b00, 8'h00, 4'h0); tick();
    check("a_sticky_hold", 32'(a_if.sticky), 32'h1);
    a_drive(2'b01, 2'b00, 2'b00, 8'h0F, 4'h0); tick();
    a_drive(2'b00, 2'b01, 2'b00, 8'h00, 4'h1); a_if.sticky_clr = 2'b01; tick();
    check("a_sticky_set_wins", 32'(a_if.sticky), 32'h1);
    a_drive(2'b00, 2'b00, 2'b00, 8'h00, 4'h0); tick();
    check("a_sticky_clear", 32'(a_if.sticky), 32'h0);
    a_if.sticky_clr = 2'b00;
`endif

    // saturate bank: underflow clamps at 0, repeated underflow re-fires
    b_drive(2'b10, 2'b00, 2'b00, 8'h20, 4'h0); tick();
    b_check("b_load2", 8'h20, 2'b01, 2'b00, 2'b00);
    b_drive(2'b00, 2'b00, 2'b10, 8'h00, 4'b1100); tick();
    b_check("b_underflow", 8'h00, 2'b11, 2'b00, 2'b10);
    b_drive(2'b00, 2'b00, 2'b10, 8'h00, 4'b0100); tick();
    b_check("b_underflow2", 8'h00, 2'b11, 2'b00, 2'b10);

    // overflow clamps at all-ones, repeated overflow re-fires
    b_drive(2'b01, 2'b00, 2'b00, 8'h0E, 4'h0); tick();
    b_check("b_load14", 8'h0E, 2'b10, 2'b00, 2'b00);
    b_drive(2'b00, 2'b01, 2'b00, 8'h00, 4'h3); tick();
    b_check("b_overflow", 8'h0F, 2'b10, 2'b01, 2'b01);
    b_drive(2'b00, 2'b01, 2'b00, 8'h00, 4'h1); tick();
    b_check("b_overflow2", 8'h0F, 2'b10, 2'b01, 2'b01);

    // landing exactly on a bound is not an event
    b_drive(2'b01, 2'b00, 2'b00, 8'h0C, 4'h0); tick();
    b_drive(2'b00, 2'b01, 2'b00, 8'h00, 4'h3); tick();
    b_check("b_exact_max", 8'h0F, 2'b10, 2'b01, 2'b00);
    b_drive(2'b01, 2'b00, 2'b00, 8'h03, 4'h0); tick();
    b_drive(2'b00, 2'b00, 2'b01, 8'h00, 4'h3); tick();
    b_check("b_exact_zero", 8'h00, 2'b11, 2'b00, 2'b00);
`ifdef BYTESWAP_COUNTER_STICKY_EN
    check("b_sticky_both", 32'(b_if.sticky), 32'h3);
`endif
    b_drive(2'b00, 2'b00, 2'b00, 8'h00, 4'h0); tick();
    b_check("b_idle", 8'h00, 2'b11, 2'b00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
